// File: rtl/psum_gbf_accum.sv
// psum_gbf_accum: partial-sum global buffer behind the su_adder.
//   Two-stage accumulate pipeline (S1 read/add, S2 write) into a DEPTH x DATA_BITWIDTH
//   store. Each entry is two SLICE_BITWIDTH halves made of independent LANE_BITWIDTH lanes.
//   Also provides entry zeroing, a registered read port, and a valid/ready drain of the
//   whole store.
// Ports:
//   clk, reset (async, active low)
//   in_data/w_en/w_addr/w_num  accumulate a slice into one half of an entry
//   init_en/init_addr          zero a whole entry
//   r_en/r_addr -> r_data/r_valid   read, one cycle latency, IDLE only
//   drain_start, drain_ready -> drain_data/drain_valid/drain_done   full-store drain
//   busy                       FSM not IDLE
//   drop_err                   sticky, w_en/init_en seen outside IDLE
// Config macro: PSUM_ACC_SAT_EN -- when defined, lane sums saturate (signed);
//   otherwise they wrap.

module psum_lane_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
`ifdef PSUM_ACC_SAT_EN
  logic [W:0] s;
  always_comb begin
    s = {a[W-1], a} + {b[W-1], b};
    // sign bits disagree -> signed overflow, clamp toward the overflow direction
    if (s[W] != s[W-1]) y = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else                y = s[W-1:0];
  end
`else
  always_comb y = a + b;
`endif
endmodule

module psum_gbf_accum #(
  parameter int LANE_BITWIDTH  = 16,
  parameter int SLICE_BITWIDTH = 256,
  parameter int DATA_BITWIDTH  = 512,
  parameter int ADDR_BITWIDTH  = 5,
  parameter int DEPTH          = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SLICE_BITWIDTH-1:0] in_data,
  input  logic                      w_en,
  input  logic [ADDR_BITWIDTH-1:0]  w_addr,
  input  logic                      w_num,
  input  logic                      init_en,
  input  logic [ADDR_BITWIDTH-1:0]  init_addr,
  input  logic                      r_en,
  input  logic [ADDR_BITWIDTH-1:0]  r_addr,
  output logic [DATA_BITWIDTH-1:0]  r_data,
  output logic                      r_valid,
  input  logic                      drain_start,
  output logic [DATA_BITWIDTH-1:0]  drain_data,
  output logic                      drain_valid,
  input  logic                      drain_ready,
  output logic                      drain_done,
  output logic                      busy,
  output logic                      drop_err
);
  localparam int NUM_LANES = SLICE_BITWIDTH / LANE_BITWIDTH;
  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN, DONE} state_t;

  state_t                     state_q;
  logic [ADDR_BITWIDTH-1:0]   cnt_q;
  logic [DATA_BITWIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_BITWIDTH-1:0]   drain_data_q, r_data_q, r_data_d;
  logic                       drain_valid_q, drain_done_q, r_valid_q, r_valid_d;
  logic                       drop_err_q, drop_err_d, idle;

  // S1: issued op; S2: op being written this cycle
  logic                       s1_wvld_q, s1_wvld_d, s1_ivld_q, s1_ivld_d, s1_half_q, s1_half_d;
  logic [ADDR_BITWIDTH-1:0]   s1_waddr_q, s1_waddr_d, s1_iaddr_q, s1_iaddr_d;
  logic [SLICE_BITWIDTH-1:0]  s1_data_q, s1_data_d;
  logic                       s2_wvld_q, s2_wvld_d, s2_ivld_q, s2_ivld_d, s2_half_q, s2_half_d;
  logic [ADDR_BITWIDTH-1:0]   s2_waddr_q, s2_waddr_d, s2_iaddr_q, s2_iaddr_d;
  logic [SLICE_BITWIDTH-1:0]  s2_sum_q, s2_sum_d;

  logic [DATA_BITWIDTH-1:0]   s1_ent, rd_ent, drain_ent;
  logic [SLICE_BITWIDTH-1:0]  s1_old, s1_sum;
  logic [ADDR_BITWIDTH-1:0]   drain_addr;

  // Overlay one pipeline op (init then half write) on an entry value read from storage.
  function automatic logic [DATA_BITWIDTH-1:0] merge(
    input logic [DATA_BITWIDTH-1:0]  ent,
    input logic [ADDR_BITWIDTH-1:0]  a,
    input logic                      ivld,
    input logic [ADDR_BITWIDTH-1:0]  iaddr,
    input logic                      wvld,
    input logic [ADDR_BITWIDTH-1:0]  waddr,
    input logic                      whalf,
    input logic [SLICE_BITWIDTH-1:0] wsum
  );
    logic [DATA_BITWIDTH-1:0] r;
    r = ent;
    if (ivld && iaddr == a) r = '0;
    if (wvld && waddr == a) begin
      if (whalf) r[DATA_BITWIDTH-1:SLICE_BITWIDTH] = wsum;
      else       r[SLICE_BITWIDTH-1:0]             = wsum;
    end
    return r;
  endfunction

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    psum_lane_add #(.W(LANE_BITWIDTH)) u_add (
      .a(s1_old[l*LANE_BITWIDTH +: LANE_BITWIDTH]),
      .b(s1_data_q[l*LANE_BITWIDTH +: LANE_BITWIDTH]),
      .y(s1_sum[l*LANE_BITWIDTH +: LANE_BITWIDTH])
    );
  end

  always_comb begin
    idle       = (state_q == IDLE);
    s1_wvld_d  = w_en && idle;
    s1_ivld_d  = init_en && idle;
    s1_waddr_d = w_addr;
    s1_iaddr_d = init_addr;
    s1_half_d  = w_num;
    s1_data_d  = in_data;
    drop_err_d = drop_err_q | ((w_en | init_en) & ~idle);

    // S1 old value: storage, then S2 forwarding, then this op's own init (zero first)
    s1_ent = merge(mem_q[s1_waddr_q], s1_waddr_q,
                   s2_ivld_q, s2_iaddr_q, s2_wvld_q, s2_waddr_q, s2_half_q, s2_sum_q);
    s1_ent = merge(s1_ent, s1_waddr_q, s1_ivld_q, s1_iaddr_q, 1'b0, '0, 1'b0, '0);
    s1_old = s1_half_q ? s1_ent[DATA_BITWIDTH-1:SLICE_BITWIDTH] : s1_ent[SLICE_BITWIDTH-1:0];

    s2_wvld_d  = s1_wvld_q;
    s2_ivld_d  = s1_ivld_q;
    s2_waddr_d = s1_waddr_q;
    s2_iaddr_d = s1_iaddr_q;
    s2_half_d  = s1_half_q;
    s2_sum_d   = s1_sum;

    rd_ent    = merge(mem_q[r_addr], r_addr,
                      s2_ivld_q, s2_iaddr_q, s2_wvld_q, s2_waddr_q, s2_half_q, s2_sum_q);
    r_valid_d = r_en && idle;
    r_data_d  = r_valid_d ? rd_ent : r_data_q;

    // Drain loads see both in-flight stages, so an op issued alongside drain_start
    // is still reflected in beat 0.
    drain_addr = (state_q == FLUSH) ? '0 : cnt_q + 1'b1;
    drain_ent  = merge(mem_q[drain_addr], drain_addr,
                       s2_ivld_q, s2_iaddr_q, s2_wvld_q, s2_waddr_q, s2_half_q, s2_sum_q);
    drain_ent  = merge(drain_ent, drain_addr,
                       s1_ivld_q, s1_iaddr_q, s1_wvld_q, s1_waddr_q, s1_half_q, s1_sum);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_wvld_q <= 1'b0; s1_ivld_q <= 1'b0; s1_half_q <= 1'b0;
      s1_waddr_q <= '0;  s1_iaddr_q <= '0;  s1_data_q <= '0;
      s2_wvld_q <= 1'b0; s2_ivld_q <= 1'b0; s2_half_q <= 1'b0;
      s2_waddr_q <= '0;  s2_iaddr_q <= '0;  s2_sum_q  <= '0;
      r_valid_q <= 1'b0; r_data_q  <= '0;   drop_err_q <= 1'b0;
    end else begin
      s1_wvld_q <= s1_wvld_d; s1_ivld_q <= s1_ivld_d; s1_half_q <= s1_half_d;
      s1_waddr_q <= s1_waddr_d; s1_iaddr_q <= s1_iaddr_d; s1_data_q <= s1_data_d;
      s2_wvld_q <= s2_wvld_d; s2_ivld_q <= s2_ivld_d; s2_half_q <= s2_half_d;
      s2_waddr_q <= s2_waddr_d; s2_iaddr_q <= s2_iaddr_d; s2_sum_q <= s2_sum_d;
      r_valid_q <= r_valid_d; r_data_q <= r_data_d; drop_err_q <= drop_err_d;
    end
  end

  // Storage has no reset; the half write lands after the init so same-entry ops compose.
  always_ff @(posedge clk) begin
    if (s2_ivld_q) mem_q[s2_iaddr_q] <= '0;
    if (s2_wvld_q) begin
      if (s2_half_q) mem_q[s2_waddr_q][DATA_BITWIDTH-1:SLICE_BITWIDTH] <= s2_sum_q;
      else           mem_q[s2_waddr_q][SLICE_BITWIDTH-1:0]             <= s2_sum_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE; cnt_q <= '0; drain_data_q <= '0;
      drain_valid_q <= 1'b0; drain_done_q <= 1'b0;
    end else begin
      drain_done_q <= 1'b0;
      case (state_q)
        IDLE:  if (drain_start) state_q <= FLUSH;
        FLUSH: begin
          state_q <= DRAIN; cnt_q <= '0;
          drain_data_q <= drain_ent; drain_valid_q <= 1'b1;
        end
        DRAIN: if (drain_valid_q && drain_ready) begin
          if (cnt_q == ADDR_BITWIDTH'(DEPTH-1)) begin
            state_q <= DONE; drain_valid_q <= 1'b0; drain_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1; drain_data_q <= drain_ent;
          end
        end
        DONE:    begin state_q <= IDLE; cnt_q <= '0; end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign r_data      = r_data_q;
  assign r_valid     = r_valid_q;
  assign drain_data  = drain_data_q;
  assign drain_valid = drain_valid_q;
  assign drain_done  = drain_done_q;
  assign busy        = (state_q != IDLE);
  assign drop_err    = drop_err_q;
endmodule

// File: tb/tb_psum_gbf_accum.sv
// Bench for psum_gbf_accum: directed vector table, randomized accumulate/init/read traffic
// against an array model, then drain, dropped-write and reset-mid-drain sequences.
// Honours PSUM_ACC_SAT_EN for the overflow expectations.
module tb_psum_gbf_accum;
  logic         clk = 1'b0, reset;
  logic [255:0] in_data;
  logic         w_en, w_num, init_en, r_en, drain_start, drain_ready;
  logic [4:0]   w_addr, init_addr, r_addr;
  logic [511:0] r_data, drain_data;
  logic         r_valid, drain_valid, drain_done, busy, drop_err;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  psum_gbf_accum dut (
    .clk(clk), .reset(reset), .in_data(in_data), .w_en(w_en), .w_addr(w_addr),
    .w_num(w_num), .init_en(init_en), .init_addr(init_addr), .r_en(r_en),
    .r_addr(r_addr), .r_data(r_data), .r_valid(r_valid), .drain_start(drain_start),
    .drain_data(drain_data), .drain_valid(drain_valid), .drain_ready(drain_ready),
    .drain_done(drain_done), .busy(busy), .drop_err(drop_err)
  );

`ifdef PSUM_ACC_SAT_EN
  localparam logic [15:0] POS_OV = 16'h7FFF, NEG_OV = 16'h8000;
`else
  localparam logic [15:0] POS_OV = 16'h8000, NEG_OV = 16'h7FFF;
`endif

  typedef struct { bit i; bit w; bit [4:0] ia; bit [4:0] wa; bit h; bit [255:0] d; } op_t;
  typedef struct { bit init; bit wr; bit [4:0] addr; bit half; bit [15:0] lane; bit rd; bit [511:0] exp; } vec_t;

  logic [511:0] mdl [32];
  vec_t vt [26];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin bad++; $display("FAIL %s got=%h want=%h", nm, act, exp); end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin bad++; $display("FAIL %s got=%0d want=%0d", nm, act, exp); end
  endtask

  task automatic tick; @(posedge clk); #1; endtask

  task automatic idle_in;
    in_data = '0; w_en = 0; w_num = 0; w_addr = '0; init_en = 0; init_addr = '0;
    r_en = 0; r_addr = '0; drain_start = 0; drain_ready = 0;
  endtask

  function automatic logic [255:0] rep(input logic [15:0] v);
    return {16{v}};
  endfunction

  // Signed per-lane add in plain integer arithmetic.
  function automatic logic [255:0] lane_add(input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r;
    int s;
    for (int l = 0; l < 16; l++) begin
      s = int'($signed(a[l*16 +: 16])) + int'($signed(b[l*16 +: 16]));
`ifdef PSUM_ACC_SAT_EN
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
`endif
      r[l*16 +: 16] = s[15:0];
    end
    return r;
  endfunction

  task automatic apply(input op_t o);
    if (o.i) mdl[o.ia] = '0;
    if (o.w) begin
      if (o.h) mdl[o.wa][511:256] = lane_add(mdl[o.wa][511:256], o.d);
      else     mdl[o.wa][255:0]   = lane_add(mdl[o.wa][255:0], o.d);
    end
  endtask

  function automatic vec_t mk(input bit init, input bit wr, input bit [4:0] a, input bit h,
                              input bit [15:0] lane, input bit rd, input bit [511:0] exp);
    vec_t v;
    v.init = init; v.wr = wr; v.addr = a; v.half = h; v.lane = lane; v.rd = rd; v.exp = exp;
    return v;
  endfunction

  initial begin
    op_t o, p1, p2;
    logic [511:0] e, held_d;
    int beats, dones;
    bit held;

    // directed table: reads are placed two cycles after the last write they must see
    vt[0]  = mk(1, 0, 3, 0, 16'h0000, 0, '0);
    vt[1]  = mk(0, 0, 0, 0, 16'h0000, 0, '0);
    vt[2]  = mk(0, 0, 3, 0, 16'h0000, 1, '0);
    vt[3]  = mk(0, 1, 3, 0, 16'h0001, 0, '0);
    vt[4]  = mk(0, 1, 3, 0, 16'h0001, 0, '0);
    vt[5]  = mk(0, 0, 0, 0, 16'h0000, 0, '0);
    vt[6]  = mk(0, 0, 3, 0, 16'h0000, 1, {256'h0, rep(16'h0002)});
    vt[7]  = mk(1, 0, 5, 0, 16'h0000, 0, '0);
    vt[8]  = mk(0, 1, 5, 1, 16'h0010, 0, '0);
    vt[9]  = mk(0, 1, 5, 1, 16'h0010, 0, '0);
    vt[10] = mk(0, 1, 5, 1, 16'h0010, 0, '0);
    vt[11] = mk(0, 1, 5, 1, 16'h0010, 0, '0);
    vt[12] = mk(0, 0, 0, 0, 16'h0000, 0, '0);
    vt[13] = mk(0, 0, 5, 0, 16'h0000, 1, {rep(16'h0040), 256'h0});
    vt[14] = mk(1, 1, 7, 0, 16'h1234, 0, '0);
    vt[15] = mk(0, 0, 0, 0, 16'h0000, 0, '0);
    vt[16] = mk(0, 0, 7, 0, 16'h0000, 1, {256'h0, rep(16'h1234)});
    vt[17] = mk(1, 0, 9, 0, 16'h0000, 0, '0);
    vt[18] = mk(0, 1, 9, 0, 16'h7FFF, 0, '0);
    vt[19] = mk(0, 1, 9, 0, 16'h0001, 0, '0);
    vt[20] = mk(0, 0, 0, 0, 16'h0000, 0, '0);
    vt[21] = mk(0, 0, 9, 0, 16'h0000, 1, {256'h0, rep(POS_OV)});
    vt[22] = mk(0, 1, 9, 1, 16'h8000, 0, '0);
    vt[23] = mk(0, 1, 9, 1, 16'hFFFF, 0, '0);
    vt[24] = mk(0, 0, 0, 0, 16'h0000, 0, '0);
    vt[25] = mk(0, 0, 9, 0, 16'h0000, 1, {rep(NEG_OV), rep(POS_OV)});

    idle_in();
    reset = 0;
    tick(); tick();
    chk("rst_r_data", r_data, '0);
    chk_i("rst_r_valid", int'(r_valid), 0);
    chk("rst_drain_data", drain_data, '0);
    chk_i("rst_drain_valid", int'(drain_valid), 0);
    chk_i("rst_drain_done", int'(drain_done), 0);
    chk_i("rst_busy", int'(busy), 0);
    chk_i("rst_drop_err", int'(drop_err), 0);
    reset = 1;
    tick();

    for (int i = 0; i < 26; i++) begin
      init_en = vt[i].init; init_addr = vt[i].addr;
      w_en = vt[i].wr; w_addr = vt[i].addr; w_num = vt[i].half; in_data = rep(vt[i].lane);
      r_en = vt[i].rd; r_addr = vt[i].addr;
      tick();
      chk_i($sformatf("vec%0d_rvalid", i), int'(r_valid), int'(vt[i].rd));
      if (vt[i].rd) chk($sformatf("vec%0d_rdata", i), r_data, vt[i].exp);
    end
    idle_in();

    // zero the whole store so the model starts defined
    for (int a = 0; a < 32; a++) begin
      init_en = 1; init_addr = 5'(a); tick();
    end
    idle_in(); tick(); tick();
    for (int a = 0; a < 32; a++) mdl[a] = '0;

    // random traffic on a few entries to force forwarding collisions
    p1 = '{default: 0}; p2 = '{default: 0};
    for (int c = 0; c < 400; c++) begin
      apply(p2);
      o.w = 1'($urandom_range(0, 1)); o.i = ($urandom_range(0, 7) == 0);
      o.wa = 5'($urandom_range(0, 3)); o.ia = 5'($urandom_range(0, 3));
      o.h = 1'($urandom_range(0, 1));
      for (int k = 0; k < 8; k++) o.d[k*32 +: 32] = $urandom;
      w_en = o.w; w_addr = o.wa; w_num = o.h; in_data = o.d;
      init_en = o.i; init_addr = o.ia;
      r_en = 1'($urandom_range(0, 1)); r_addr = 5'($urandom_range(0, 3));
      e = mdl[r_addr];
      tick();
      chk_i($sformatf("rnd%0d_rvalid", c), int'(r_valid), int'(r_en));
      if (r_en) chk($sformatf("rnd%0d_rdata", c), r_data, e);
      p2 = p1; p1 = o;
    end
    apply(p2); apply(p1);
    idle_in(); tick(); tick();

    // drain with toggling ready, a dropped write, an ignored read and drain_start
    drain_start = 1; tick(); drain_start = 0;
    chk_i("drain_busy", int'(busy), 1);
    beats = 0; dones = 0; held = 0; held_d = '0;
    for (int cyc = 0; cyc < 110; cyc++) begin
      drain_ready = cyc[0];
      w_en = (cyc == 3); w_addr = 0; w_num = 0; in_data = rep(16'h0101);
      r_en = (cyc == 4); r_addr = 0;
      drain_start = (cyc == 6);
      if (drain_valid && held) chk($sformatf("hold_b%0d", beats), drain_data, held_d);
      if (drain_valid && drain_ready) begin
        if (beats < 32) chk($sformatf("beat%0d", beats), drain_data, mdl[beats]);
        beats++;
      end
      held = drain_valid && !drain_ready; held_d = drain_data;
      tick();
      if (cyc == 4) chk_i("drain_rvalid", int'(r_valid), 0);
      if (drain_done) begin
        dones++;
        chk_i("done_after_beats", beats, 32);
      end
    end
    idle_in();
    chk_i("drain_done_count", dones, 1);
    chk_i("drain_beats", beats, 32);
    chk_i("drain_drop_err", int'(drop_err), 1);
    chk_i("drain_end_busy", int'(busy), 0);
    chk_i("drain_end_valid", int'(drain_valid), 0);

    // reset in the middle of a drain
    drain_start = 1; tick(); drain_start = 0; drain_ready = 1;
    repeat (6) tick();
    chk_i("mid_drain_valid", int'(drain_valid), 1);
    reset = 0; #1;
    chk_i("mrst_valid", int'(drain_valid), 0);
    chk_i("mrst_busy", int'(busy), 0);
    chk_i("mrst_done", int'(drain_done), 0);
    chk_i("mrst_drop_err", int'(drop_err), 0);
    idle_in(); tick(); reset = 1; tick();
    chk_i("mrst_done_after", int'(drain_done), 0);
    chk_i("mrst_busy_after", int'(busy), 0);
    r_en = 1; r_addr = 2; tick(); r_en = 0;
    chk("mrst_store_kept", r_data, mdl[2]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
